// File: rtl/i2c_pkg.sv
// Shared types and bit-timing helpers for the I2C transfer master.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_ACK,
      ST_STOP,
      ST_DONE
   } state_t;

   function automatic int phase_q1(input int div);
      return div / 4;
   endfunction

   function automatic int phase_half(input int div);
      return div / 2;
   endfunction

   function automatic int phase_q3(input int div);
      return (3 * div) / 4;
   endfunction

   // Width that can hold a byte count 0..n.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Per-bit phase counter: SCL level plus strobes at mid-low, mid-high and end of each bit period.
module i2c_bit_timer
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 128
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output logic o_scl_hi,
   output logic o_q1_stb,
   output logic o_q3_stb,
   output logic o_end_stb
);

   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] P_Q1   = PW'(phase_q1(CLK_DIV));
   localparam logic [PW-1:0] P_HALF = PW'(phase_half(CLK_DIV));
   localparam logic [PW-1:0] P_Q3   = PW'(phase_q3(CLK_DIV));
   localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] r_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_phase <= '0;
      else if (!i_en)             r_phase <= '0;
      else if (r_phase == P_LAST) r_phase <= '0;
      else                        r_phase <= r_phase + PW'(1);
   end

   assign o_scl_hi  = (r_phase >= P_HALF);
   assign o_q1_stb  = i_en && (r_phase == P_Q1);
   assign o_q3_stb  = i_en && (r_phase == P_Q3);
   assign o_end_stb = i_en && (r_phase == P_LAST);

endmodule

// File: rtl/i2c_master_xfer.sv
// I2C master: START, 1..NBYTES_MAX bytes (write, or address + reads), STOP, with per-byte ACK status.
// Build option: define I2C_ABORT_ON_NACK_EN to jump to STOP after any NACKed written byte.
module i2c_master_xfer
   import i2c_pkg::*;
#(
   parameter int NBYTES_MAX = 4,
   parameter int CLK_DIV    = 128
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [cnt_w(NBYTES_MAX)-1:0] nbytes,
   input  logic [8*NBYTES_MAX-1:0]      wr_data,
   output logic [8*NBYTES_MAX-1:0]      rd_data,
   output logic [NBYTES_MAX-1:0]        ack_vec,
   output logic                         ack_err,
   output logic                         busy,
   output logic                         done,
   output logic                         i2c_sclk,
   inout  wire                          i2c_sdat
);

   localparam int NB_W = cnt_w(NBYTES_MAX);
   localparam int DW   = 8 * NBYTES_MAX;

   state_t          r_state, w_next;
   logic [NB_W-1:0] r_nbytes, r_byte_idx, w_nb_clamp;
   logic [2:0]      r_bit_cnt;
   logic [DW-1:0]   r_tx;
   logic [7:0]      r_rx;
   logic            r_rd_mode, r_sda_lo;
   logic            w_run, w_scl_hi, w_q1, w_q3, w_end;
   logic            w_sda_in, w_is_read, w_last, w_accept, w_abort;

   assign w_run = (r_state == ST_START) || (r_state == ST_BIT) ||
                  (r_state == ST_ACK)   || (r_state == ST_STOP);

   i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (w_run),
      .o_scl_hi  (w_scl_hi),
      .o_q1_stb  (w_q1),
      .o_q3_stb  (w_q3),
      .o_end_stb (w_end)
   );

   // Lines are decoded straight from async-reset state so a reset releases them at once.
   assign i2c_sdat = r_sda_lo ? 1'b0 : 1'bz;
   assign w_sda_in = i2c_sdat;
   assign i2c_sclk = (r_state == ST_BIT || r_state == ST_ACK || r_state == ST_STOP) ? w_scl_hi : 1'b1;
   assign busy     = w_run;
   assign done     = (r_state == ST_DONE);

   assign w_accept   = (r_state == ST_IDLE) && start;
   assign w_nb_clamp = (int'(nbytes) > NBYTES_MAX) ? NB_W'(NBYTES_MAX) : nbytes;
   assign w_is_read  = r_rd_mode && (r_byte_idx != '0);
   assign w_last     = (r_byte_idx == r_nbytes - NB_W'(1));

`ifdef I2C_ABORT_ON_NACK_EN
   logic r_nack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_nack <= 1'b0;
      else if (r_state != ST_ACK)             r_nack <= 1'b0;
      else if (w_q3)                          r_nack <= !w_is_read && w_sda_in;
   end

   assign w_abort = r_nack;
`else
   logic w_abort_unused;
   assign w_abort        = 1'b0;
   assign w_abort_unused = w_abort;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_accept) w_next = (w_nb_clamp == '0) ? ST_DONE : ST_START;
         ST_START: if (w_end) w_next = ST_BIT;
         ST_BIT:   if (w_end && r_bit_cnt == 3'd7) w_next = ST_ACK;
         ST_ACK:   if (w_end) w_next = (w_last || w_abort) ? ST_STOP : ST_BIT;
         ST_STOP:  if (w_end) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nbytes   <= '0;
         r_byte_idx <= '0;
         r_bit_cnt  <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_rd_mode  <= 1'b0;
         r_sda_lo   <= 1'b0;
         rd_data    <= '0;
         ack_vec    <= '0;
         ack_err    <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: if (w_accept) begin
               r_nbytes   <= w_nb_clamp;
               r_tx       <= wr_data;
               r_rd_mode  <= wr_data[DW-8];
               r_byte_idx <= '0;
               r_bit_cnt  <= '0;
               r_sda_lo   <= 1'b0;
               rd_data    <= '0;
               ack_vec    <= '0;
               ack_err    <= 1'b0;
            end
            ST_START: if (w_q3) r_sda_lo <= 1'b1;
            ST_BIT: begin
               if (w_q1) r_sda_lo <= w_is_read ? 1'b0 : !r_tx[DW-1];
               if (w_q3 && w_is_read) r_rx <= {r_rx[6:0], w_sda_in};
               // Shift on read bytes too so the next written byte stays aligned at the top.
               if (w_end) begin
                  r_tx      <= r_tx << 1;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            ST_ACK: begin
               if (w_q1) begin
                  r_sda_lo <= w_is_read && !w_last;
                  if (w_is_read)
                     for (int k = 1; k < NBYTES_MAX; k++)
                        if (r_byte_idx == NB_W'(k)) rd_data[DW-1-8*k -: 8] <= r_rx;
               end
               if (w_q3 && !w_is_read) begin
                  for (int k = 0; k < NBYTES_MAX; k++)
                     if (r_byte_idx == NB_W'(k)) ack_vec[NBYTES_MAX-1-k] <= !w_sda_in;
                  if (w_sda_in) ack_err <= 1'b1;
               end
               if (w_end) r_byte_idx <= r_byte_idx + NB_W'(1);
            end
            ST_STOP: begin
               if (w_q1) r_sda_lo <= 1'b1;
               if (w_q3) r_sda_lo <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
